move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, move-code FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1000, idle clocks inserted after each completed move (>=1).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  permits batch requests.
REQ-006 SHALL have port moves  input  60  batch of 15 packed 4-bit move codes, nibble 14 = bits 59:56.
REQ-007 SHALL have port new_moves  input  1  one-cycle strobe; moves valid in that cycle.
REQ-008 SHALL have port send_setup_moves  output  1  one-cycle request to upstream batch generator.
REQ-009 SHALL have port move_out  output  4  move code presented to motor driver.
REQ-010 SHALL have port move_valid  output  1  move_out valid, held until move_done.
REQ-011 SHALL have port move_done  input  1  one-cycle completion pulse from motor driver.
REQ-012 SHALL have port busy  output  1  high when any move is pending, unpacking or executing.
REQ-013 SHALL have port moves_executed  output  8  count of completed moves, wraps 255->0.
REQ-014 SHALL have port error  output  1  sticky: batch dropped.

Function
REQ-015 SHALL treat codes 2..13 (R,R',U,U',F,F',L,L',B,B',D,D') as valid; codes 0,1,14,15 are null and discarded.
REQ-016 SHALL, on new_moves while unpacker idle, capture moves into a shift register in that cycle.
REQ-017 SHALL unpack one nibble per clock, nibble 14 first down to nibble 0, pushing only valid codes into the FIFO; 15 cycles per batch when unstalled.
REQ-018 SHALL stall unpacking (no nibble consumed) while the FIFO is full.
REQ-019 SHALL drop a new_moves arriving while unpacking, and set error; the batch in progress continues unaffected.
REQ-020 SHALL allow FIFO push and pop in the same cycle; occupancy then unchanged.
REQ-021 Executor FSM SHALL have states IDLE, ISSUE, WAIT_DONE, SETTLE.
REQ-022 IDLE -> ISSUE when FIFO non-empty; ISSUE pops head into move_out, asserts move_valid, -> WAIT_DONE next cycle.
REQ-023 WAIT_DONE SHALL hold move_out/move_valid stable; on move_done: deassert move_valid, increment moves_executed, -> SETTLE.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES clocks, then -> IDLE; first move_valid of the next move rises 2 clocks after SETTLE ends (IDLE, ISSUE).
REQ-025 move_done outside WAIT_DONE SHALL be ignored.
REQ-026 send_setup_moves SHALL pulse one cycle when enable=1, FIFO empty, unpacker idle, executor IDLE, and no request is outstanding.
REQ-027 A request SHALL remain outstanding (no further pulse) until the next accepted new_moves.
REQ-028 An accepted batch containing only null codes SHALL clear the outstanding request, producing a new pulse 16 cycles after capture if conditions of REQ-026 hold.
REQ-029 busy SHALL equal (FIFO non-empty) OR (unpacker active) OR (executor not IDLE).
REQ-030 Deasserting enable SHALL only suppress new requests; queued moves still execute.

Reset
REQ-031 SHALL, while reset_n=0, force: send_setup_moves=0, move_out=0, move_valid=0, busy=0, moves_executed=0, error=0, FIFO empty, unpacker idle, executor IDLE, no request outstanding.
REQ-032 Reset asserted mid-move SHALL abandon that move and all queued moves; no move_done is awaited after release.
REQ-033 After reset_n rises with enable=1, send_setup_moves SHALL pulse on the second rising edge.

Verification
REQ-034 moves=60'h000_0000_0000_046B, new_moves pulse -> move_out 4, 6, 11 in order, each held until move_done; moves_executed=3; then one send_setup_moves pulse.
REQ-035 moves all nibbles=4'h4 (15 U), FIFO_DEPTH=4, move_done delayed 50 cycles -> unpacker stalls at full, all 15 moves issued in order, none lost, error=0.
REQ-036 second new_moves 5 cycles after first -> second batch ignored, error=1 and stays 1 until reset; first batch executes fully.
REQ-037 move_done pulsed during SETTLE and IDLE -> no count change, no state change; SETTLE_CYCLES=3 measured as exactly 3 clocks between move_valid fall and next IDLE.
REQ-038 reset_n low during WAIT_DONE with 5 queued moves -> all outputs reset values; after release no stale move_out issued; moves_executed=0.
REQ-039 256 completed moves -> moves_executed wraps to 0.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: unpacks 15-code move batches into a FIFO and issues them
// one at a time to a motor driver, with a settle gap after every move.
//
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   enable                  : permits batch requests upstream
//   moves[59:0], new_moves  : packed batch (nibble 14 first) + strobe
//   send_setup_moves        : one-cycle batch request
//   move_out, move_valid    : current move, held until move_done
//   move_done               : completion pulse from motor driver
//   busy, moves_executed    : activity flag, wrapping completed-move count
//   error                   : sticky, a batch was dropped
module move_sequencer #(
  parameter int FIFO_DEPTH    = 16,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [59:0] moves,
  input  logic        new_moves,
  output logic        send_setup_moves,
  output logic [3:0]  move_out,
  output logic        move_valid,
  input  logic        move_done,
  output logic        busy,
  output logic [7:0]  moves_executed,
  output logic        error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_SETTLE
  } state_t;

  // FIFO
  logic [3:0]  r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [3:0]  w_head;

  // unpacker
  logic [59:0] r_shift;
  logic [3:0]  r_nib_cnt;
  logic        r_active;
  logic [3:0]  w_nib;
  logic        w_code_ok;
  logic        w_consume;
  logic        w_accept;

  // request / status
  logic        r_err;
  logic        r_req_out;
  logic        r_send;
  logic        r_started;
  logic        w_req;

  // executor
  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_move_out;
  logic [3:0]  w_move_nx;
  logic        r_valid;
  logic        w_valid_nx;
  logic [7:0]  r_count;
  logic [7:0]  w_count_nx;
  logic [SW-1:0] r_settle;
  logic [SW-1:0] w_settle_nx;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_fifo[r_rptr[AW-1:0]];

  assign w_nib     = r_shift[59:56];
  assign w_code_ok = (w_nib >= 4'd2) && (w_nib <= 4'd13);
  // a full FIFO freezes the unpacker; the nibble stays at the head
  assign w_consume = r_active && !w_full;
  assign w_push    = w_consume && w_code_ok;
  assign w_accept  = new_moves && !r_active;

  // r_started delays the first request to the second edge after reset
  assign w_req = enable && w_empty && !r_active &&
                 (r_state == S_IDLE) && !r_req_out &&
                 r_started && !w_accept;

  always_ff @(posedge clock) begin
    if (w_push)
      r_fifo[r_wptr[AW-1:0]] <= w_nib;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_shift   <= '0;
      r_nib_cnt <= '0;
      r_active  <= 1'b0;
      r_err     <= 1'b0;
      r_req_out <= 1'b0;
      r_send    <= 1'b0;
      r_started <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;

      if (w_accept) begin
        r_shift   <= moves;
        r_nib_cnt <= 4'd14;
        r_active  <= 1'b1;
      end else if (w_consume) begin
        r_shift <= {r_shift[55:0], 4'h0};
        if (r_nib_cnt == 4'd0)
          r_active <= 1'b0;
        else
          r_nib_cnt <= r_nib_cnt - 4'd1;
      end

      if (new_moves && r_active)
        r_err <= 1'b1;

      if (w_accept)
        r_req_out <= 1'b0;
      else if (w_req)
        r_req_out <= 1'b1;

      r_send    <= w_req;
      r_started <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_move_out <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_settle   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_move_out <= w_move_nx;
      r_valid    <= w_valid_nx;
      r_count    <= w_count_nx;
      r_settle   <= w_settle_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_move_nx   = r_move_out;
    w_valid_nx  = r_valid;
    w_count_nx  = r_count;
    w_settle_nx = r_settle;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty)
          w_state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        w_pop      = 1'b1;
        w_move_nx  = w_head;
        w_valid_nx = 1'b1;
        w_state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (move_done) begin
          w_valid_nx  = 1'b0;
          w_count_nx  = r_count + 8'd1;
          w_settle_nx = SW'(SETTLE_CYCLES - 1);
          w_state_nx  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle == '0)
          w_state_nx = S_IDLE;
        else
          w_settle_nx = r_settle - SW'(1);
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign send_setup_moves = r_send;
  assign move_out         = r_move_out;
  assign move_valid       = r_valid;
  assign moves_executed   = r_count;
  assign error            = r_err;
  assign busy = !w_empty || r_active || (r_state != S_IDLE);

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed scoreboard bench for move_sequencer
// (FIFO_DEPTH=4, SETTLE_CYCLES=3).
module tb_move_sequencer;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [59:0] moves = '0;
  logic        new_moves = 1'b0;
  logic        move_done = 1'b0;
  logic        send_setup_moves;
  logic [3:0]  move_out;
  logic        move_valid;
  logic        busy;
  logic [7:0]  moves_executed;
  logic        error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sends = 0;
  int last_send_cyc = 0;
  int n_rises = 0;
  int n_falls = 0;
  int last_rise_cyc = 0;
  int last_fall_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_send = 1'b0;
  logic [3:0] held = '0;
  bit resp_en = 1'b1;
  int done_delay = 0;
  bit pend = 1'b0;
  int wcnt = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp_cnt = '0;

  always #5 clock = ~clock;

  move_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .moves           (moves),
    .new_moves       (new_moves),
    .send_setup_moves(send_setup_moves),
    .move_out        (move_out),
    .move_valid      (move_valid),
    .move_done       (move_done),
    .busy            (busy),
    .moves_executed  (moves_executed),
    .error           (error)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample #1 after the edge, run scoreboard and done responder
  task automatic tick();
    logic done_prev;
    logic [3:0] e;
    done_prev = move_done;
    @(posedge clock);
    #1;
    cyc++;
    move_done = 1'b0;
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_send = 1'b0;
      pend = 1'b0;
    end else begin
      if (send_setup_moves) begin
        sends++;
        last_send_cyc = cyc;
        chk("send_one_cycle", prev_send, 0);
      end
      prev_send = send_setup_moves;
      if (move_valid && !prev_valid) begin
        n_rises++;
        last_rise_cyc = cyc;
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL issue_unexpected observed=%0h expected=none",
                 move_out);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("issue_order", move_out, e);
        end
        held = move_out;
        if (resp_en) begin
          pend = 1'b1;
          wcnt = done_delay;
        end
      end else if (move_valid) begin
        chk("hold_stable", move_out, held);
      end else if (prev_valid) begin
        n_falls++;
        last_fall_cyc = cyc;
        chk("fall_after_done", done_prev, 1);
      end
      if (pend) begin
        if (wcnt == 0) begin
          move_done = 1'b1;
          pend = 1'b0;
        end else begin
          wcnt--;
        end
      end
      prev_valid = move_valid;
    end
  endtask

  task automatic drive_batch(input logic [59:0] m, input bit accept);
    logic [3:0] n;
    if (accept) begin
      for (int i = 14; i >= 0; i--) begin
        n = m[i*4 +: 4];
        if (n >= 4'd2 && n <= 4'd13) begin
          exp_q.push_back(n);
          exp_cnt = exp_cnt + 8'd1;
        end
      end
    end
    moves = m;
    new_moves = 1'b1;
    tick();
    new_moves = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < max) begin
      tick();
      k++;
    end
    chk(tag, busy, 0);
    chk({tag, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int s0;
    int cap;
    int r0;
    int f0;
    int f1;
    logic [59:0] m;
    int n;

    // reset values
    tick();
    tick();
    chk("rst_send", send_setup_moves, 0);
    chk("rst_move_out", move_out, 0);
    chk("rst_valid", move_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", moves_executed, 0);
    chk("rst_error", error, 0);

    // request on second edge after release
    enable = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("req_edge1", send_setup_moves, 0);
    tick();
    chk("req_edge2", send_setup_moves, 1);
    s0 = sends;
    for (int i = 0; i < 6; i++) tick();
    chk("req_outstanding", sends, s0);

    // basic batch 4,6,11
    done_delay = 0;
    s0 = sends;
    drive_batch(60'h000_0000_0000_046B, 1);
    chk("busy_after_capture", busy, 1);
    wait_idle(400, "basic_idle");
    chk("basic_count", moves_executed, exp_cnt);
    for (int i = 0; i < 3; i++) tick();
    chk("basic_one_request", sends - s0, 1);

    // all-null batch re-arms request 16 cycles after capture
    s0 = sends;
    r0 = n_rises;
    drive_batch(60'hFE1_0FE1_0FE1_0FE1, 1);
    cap = cyc;
    for (int i = 0; i < 40 && sends == s0; i++) tick();
    chk("null_request_gap", last_send_cyc - cap, 16);
    chk("null_no_issue", n_rises, r0);
    chk("null_count", moves_executed, exp_cnt);

    // mixed batch, nulls stripped, moderate done delay
    done_delay = 7;
    drive_batch(60'h234_5678_9ABC_D01F, 1);
    wait_idle(800, "mixed_idle");
    chk("mixed_count", moves_executed, exp_cnt);

    // 15 U with slow done: unpacker stalls on full FIFO
    done_delay = 50;
    drive_batch(60'h444_4444_4444_4444, 1);
    wait_idle(3000, "stall_idle");
    chk("stall_count", moves_executed, exp_cnt);
    chk("stall_error", error, 0);

    // second batch 5 cycles later is dropped
    done_delay = 0;
    drive_batch(60'h000_0000_0000_0789, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("drop_pre_error", error, 0);
    drive_batch(60'h000_0000_0000_0DDD, 0);
    chk("drop_error_set", error, 1);
    wait_idle(400, "drop_idle");
    chk("drop_count", moves_executed, exp_cnt);
    chk("drop_error_sticky", error, 1);

    // settle length, stray move_done in SETTLE and IDLE
    drive_batch(60'h000_0000_0000_0023, 1);
    f0 = n_falls;
    for (int i = 0; i < 200 && n_falls == f0; i++) tick();
    f1 = last_fall_cyc;
    r0 = n_rises;
    move_done = 1'b1;
    tick();
    chk("settle_stray_count", moves_executed, exp_cnt - 8'd1);
    chk("settle_stray_valid", move_valid, 0);
    for (int i = 0; i < 40 && n_rises == r0; i++) tick();
    chk("next_issue_gap", last_rise_cyc - f1, SETTLE + 2);
    f0 = n_falls;
    for (int i = 0; i < 200 && n_falls == f0; i++) tick();
    f1 = last_fall_cyc;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("settle_len", cyc - f1, SETTLE);
    move_done = 1'b1;
    tick();
    tick();
    chk("idle_stray_count", moves_executed, exp_cnt);
    chk("idle_stray_valid", move_valid, 0);
    chk("idle_stray_busy", busy, 0);

    // reset in WAIT_DONE with queued moves
    resp_en = 1'b0;
    drive_batch(60'h000_0000_0078_9ABC, 1);
    r0 = n_rises;
    for (int i = 0; i < 40 && n_rises == r0; i++) tick();
    tick();
    tick();
    chk("pre_reset_valid", move_valid, 1);
    chk("pre_reset_error", error, 1);
    reset_n = 1'b0;
    #1;
    chk("async_valid", move_valid, 0);
    chk("async_move_out", move_out, 0);
    chk("async_busy", busy, 0);
    chk("async_error", error, 0);
    chk("async_send", send_setup_moves, 0);
    chk("async_count", moves_executed, 0);
    exp_q.delete();
    exp_cnt = '0;
    tick();
    tick();
    reset_n = 1'b1;
    resp_en = 1'b1;
    r0 = n_rises;
    tick();
    chk("rerst_edge1", send_setup_moves, 0);
    tick();
    chk("rerst_edge2", send_setup_moves, 1);
    for (int i = 0; i < 40; i++) tick();
    chk("rerst_no_stale", n_rises, r0);
    chk("rerst_count", moves_executed, 0);
    chk("rerst_busy", busy, 0);

    // 256 moves: counter wraps
    n = 0;
    for (int b = 0; b < 18; b++) begin
      m = '0;
      for (int i = 0; i < 15; i++) begin
        if (b < 17 || i == 14) begin
          m[i*4 +: 4] = 4'(2 + (n % 12));
          n++;
        end
      end
      drive_batch(m, 1);
      wait_idle(400, "wrap_idle");
      if (b == 16)
        chk("wrap_255", moves_executed, 255);
    end
    chk("wrap_0", moves_executed, 0);
    chk("wrap_model", moves_executed, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
